reset_ctrl: RTL and testbench

RESET_CTRL -- requirements
Module: reset_ctrl

---
 rtl/toysoc_rst_pkg.sv | 25 ++
 rtl/rst_debounce.sv | 54 +++++
 rtl/reset_ctrl.sv | 117 +++++++++++
 tb/tb_reset_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/toysoc_rst_pkg.sv
// Shared reset-controller types: FSM state encoding and reset-cause bit positions.
// Latency: none, declarations only.
// Backpressure: not applicable.
package toysoc_rst_pkg;

   // Controller state: normal operation, timed reset pulse, hold until button release
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_PULSE    = 2'd1,
      ST_WAIT_REL = 2'd2
   } rst_state_t;

   // Sticky reset-cause vector layout {por, wdt, sw, btn}
   localparam int CAUSE_BTN = 0;
   localparam int CAUSE_SW  = 1;
   localparam int CAUSE_WDT = 2;
   localparam int CAUSE_POR = 3;
   localparam int CAUSE_W   = 4;

   typedef logic [CAUSE_W-1:0] cause_t;

   // Cause value loaded by power-on reset
   localparam cause_t CAUSE_POR_ONLY = 4'b1000;

endpackage

// File: rtl/rst_debounce.sv
// Button conditioner: 2-flop synchronizer then N-sample debounce, plus press-event pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES samples; press pulse appears with the new debounced level.
// Backpressure: none; the button is sampled every cycle.
module rst_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn_n,
   output logic o_btn_n_deb,
   output logic o_press
);

   localparam int                CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]     CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // Bring the asynchronous button into the clock domain; idle level is released (1)
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= i_btn_n;
         sync2 <= sync1;
      end
   end

   // Accept a new level only after a run of differing samples; any agreeing sample restarts the run
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_btn_n_deb <= 1'b1;
         o_press     <= 1'b0;
         cnt         <= '0;
      end else begin
         o_press <= 1'b0;
         if (sync2 != o_btn_n_deb) begin
            if (cnt == CNT_LAST) begin
               o_btn_n_deb <= sync2;
               o_press     <= ~sync2;
               cnt         <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/reset_ctrl.sv
// System reset controller: merges button, software and watchdog sources into a timed reset pulse.
// Latency: a source firing in cycle N raises o_sys_rst in cycle N+1 for RST_PULSE_CYCLES cycles minimum.
// Backpressure: none; requests arriving while reset is active are dropped.
module reset_ctrl
   import toysoc_rst_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES  = 16,
   parameter int RST_PULSE_CYCLES = 8,
   parameter int WDT_TIMEOUT      = 65536
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_btn_n,
   input  logic         i_sw_rst_req,
   input  logic         i_wdt_en,
   input  logic         i_wdt_kick,
   input  logic         i_cause_clr,
   output logic         o_sys_rst,
   output logic [3:0]   o_rst_cause
);

   localparam int            WW         = $clog2(WDT_TIMEOUT);
   localparam logic [WW-1:0] WDT_LAST   = WW'(WDT_TIMEOUT - 1);
   localparam int            PW         = $clog2(RST_PULSE_CYCLES);
   localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);

   rst_state_t    state;
   logic [PW-1:0] pulse_cnt;
   logic [WW-1:0] wdt_cnt;
   cause_t        cause;
   cause_t        cause_kept;
   cause_t        fired;
   logic          wdt_expire;
   logic          btn_n_deb;
   logic          btn_press;

   rst_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_btn_n     (i_btn_n),
      .o_btn_n_deb (btn_n_deb),
      .o_press     (btn_press)
   );

   // Decode which reset sources fire this cycle; clear is applied before new causes are OR-ed in
   always_comb begin
      wdt_expire        = (state == ST_RUN) && i_wdt_en && !i_wdt_kick && (wdt_cnt == WDT_LAST);
      fired             = '0;
      fired[CAUSE_BTN]  = btn_press;
      fired[CAUSE_SW]   = i_sw_rst_req;
      fired[CAUSE_WDT]  = wdt_expire;
      cause_kept        = i_cause_clr ? cause_t'('0) : cause;
   end

   // Reset sequencing FSM with registered reset output, watchdog counter and sticky causes
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= ST_PULSE;
         pulse_cnt <= '0;
         wdt_cnt   <= '0;
         o_sys_rst <= 1'b1;
         cause     <= CAUSE_POR_ONLY;
      end else begin
         cause <= cause_kept;
         case (state)
            ST_RUN: begin
               if (fired != '0) begin
                  state     <= ST_PULSE;
                  pulse_cnt <= '0;
                  wdt_cnt   <= '0;
                  o_sys_rst <= 1'b1;
                  cause     <= cause_kept | fired;
               end else begin
                  o_sys_rst <= 1'b0;
                  if (!i_wdt_en || i_wdt_kick) begin
                     wdt_cnt <= '0;
                  end else begin
                     wdt_cnt <= wdt_cnt + 1'b1;
                  end
               end
            end
            ST_PULSE: begin
               wdt_cnt <= '0;
               if (pulse_cnt == PULSE_LAST) begin
                  pulse_cnt <= '0;
                  if (btn_n_deb) begin
                     state     <= ST_RUN;
                     o_sys_rst <= 1'b0;
                  end else begin
                     state <= ST_WAIT_REL;
                  end
               end else begin
                  pulse_cnt <= pulse_cnt + 1'b1;
               end
            end
            ST_WAIT_REL: begin
               wdt_cnt <= '0;
               if (btn_n_deb) begin
                  state     <= ST_RUN;
                  o_sys_rst <= 1'b0;
               end
            end
            default: begin
               state     <= ST_PULSE;
               pulse_cnt <= '0;
               wdt_cnt   <= '0;
               o_sys_rst <= 1'b1;
            end
         endcase
      end
   end

   assign o_rst_cause = cause;

endmodule

// File: tb/tb_reset_ctrl.sv
// Bench for reset_ctrl: directed scenarios plus random traffic against a cycle-level reference model.
// Latency: expected outputs are queued one cycle ahead and compared on the following falling edge.
// Backpressure: not applicable.
module tb_reset_ctrl;

   localparam int DEB = 4;
   localparam int PUL = 8;
   localparam int WDT = 100;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic       i_btn_n;
   logic       i_sw_rst_req;
   logic       i_wdt_en;
   logic       i_wdt_kick;
   logic       i_cause_clr;
   logic       o_sys_rst;
   logic [3:0] o_rst_cause;

   always #5 i_clk = ~i_clk;

   reset_ctrl #(
      .DEBOUNCE_CYCLES  (DEB),
      .RST_PULSE_CYCLES (PUL),
      .WDT_TIMEOUT      (WDT)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_btn_n      (i_btn_n),
      .i_sw_rst_req (i_sw_rst_req),
      .i_wdt_en     (i_wdt_en),
      .i_wdt_kick   (i_wdt_kick),
      .i_cause_clr  (i_cause_clr),
      .o_sys_rst    (o_sys_rst),
      .o_rst_cause  (o_rst_cause)
   );

   int         n_checks = 0;
   int         n_errors = 0;
   logic [4:0] exp_q[$];

   // Reference model: absolute cycle numbers instead of counters
   int         m_cyc = 0;
   int         m_phase = 1;       // 0 running, 1 timed pulse, 2 waiting for button release
   int         m_pulse_end = 0;   // last cycle of the timed pulse
   int         m_wdt_base = 0;    // cycle at which the watchdog count was last zero
   logic [3:0] m_cause = 4'b1000;
   logic       m_sysrst = 1'b1;
   logic       m_d1 = 1'b1, m_d2 = 1'b1, m_deb = 1'b1, m_press = 1'b0;
   int         m_streak = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_step();
      logic       n_deb, n_press;
      int         n_streak;
      logic [3:0] fired, kept;
      if (i_rst) begin
         m_d1 = 1'b1; m_d2 = 1'b1; m_deb = 1'b1; m_streak = 0; m_press = 1'b0;
         m_phase = 1; m_pulse_end = m_cyc + PUL; m_cause = 4'b1000; m_sysrst = 1'b1;
      end else begin
         n_deb = m_deb; n_streak = 0; n_press = 1'b0;
         if (m_d2 != m_deb) begin
            n_streak = m_streak + 1;
            if (n_streak == DEB) begin
               n_deb = m_d2; n_streak = 0; n_press = !m_d2;
            end
         end
         kept = i_cause_clr ? 4'b0000 : m_cause;
         m_cause = kept;
         if (m_phase == 0) begin
            fired = {1'b0, (i_wdt_en && !i_wdt_kick && (m_cyc - m_wdt_base == WDT - 1)),
                     i_sw_rst_req, m_press};
            if (fired != 4'b0000) begin
               m_phase = 1; m_pulse_end = m_cyc + PUL; m_sysrst = 1'b1; m_cause = kept | fired;
            end else if (!i_wdt_en || i_wdt_kick) begin
               m_wdt_base = m_cyc + 1;
            end
         end else if (m_phase == 1) begin
            if (m_cyc == m_pulse_end) begin
               if (m_deb) begin
                  m_phase = 0; m_sysrst = 1'b0; m_wdt_base = m_cyc + 1;
               end else begin
                  m_phase = 2;
               end
            end
         end else if (m_deb) begin
            m_phase = 0; m_sysrst = 1'b0; m_wdt_base = m_cyc + 1;
         end
         m_d2 = m_d1; m_d1 = i_btn_n; m_deb = n_deb; m_streak = n_streak; m_press = n_press;
      end
      m_cyc++;
      exp_q.push_back({m_sysrst, m_cause});
   endtask

   // Apply current inputs for one cycle: queue the model's prediction, then advance past the edge
   task automatic step();
      model_step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Count consecutive high cycles of o_sys_rst starting with the current one
   task automatic measure(output int n);
      n = 0;
      while (o_sys_rst && n < 100) begin
         n++;
         step();
      end
   endtask

   // Monitor: compare DUT outputs with the oldest queued prediction on each falling edge
   initial begin : monitor
      logic [4:0] e;
      forever begin
         @(negedge i_clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({o_sys_rst, o_rst_cause} !== e) begin
               n_errors++;
               $display("FAIL scoreboard t=%0t: got rst=%b cause=%b expected rst=%b cause=%b",
                        $time, o_sys_rst, o_rst_cause, e[4], e[3:0]);
            end
         end
      end
   end

   initial begin : driver
      int   n;
      logic saw;
      int   btn_left;
      i_rst = 1'b1; i_btn_n = 1'b1; i_sw_rst_req = 1'b0;
      i_wdt_en = 1'b0; i_wdt_kick = 1'b0; i_cause_clr = 1'b0;

      // Power-on
      step();
      chk("reset_sys_rst", o_sys_rst, 1);
      chk("reset_cause", o_rst_cause, 4'b1000);
      step(); step();
      i_rst = 1'b0;
      measure(n);
      chk("por_pulse_len", n, PUL);
      chk("por_cause", o_rst_cause, 4'b1000);
      idle(5);

      // Software reset
      i_sw_rst_req = 1'b1; step(); i_sw_rst_req = 1'b0;
      measure(n);
      chk("sw_pulse_len", n, PUL);
      chk("sw_cause", o_rst_cause, 4'b1010);
      idle(3);

      // Software request coinciding with watchdog expiry
      i_wdt_en = 1'b1;
      idle(WDT - 1);
      i_sw_rst_req = 1'b1; step(); i_sw_rst_req = 1'b0; i_wdt_en = 1'b0;
      chk("simul_cause", o_rst_cause, 4'b1110);
      measure(n);
      chk("simul_pulse_len", n, PUL);
      idle(3);

      // Clear, then clear together with a new request
      i_cause_clr = 1'b1; step(); i_cause_clr = 1'b0;
      chk("clear_cause", o_rst_cause, 4'b0000);
      i_cause_clr = 1'b1; i_sw_rst_req = 1'b1; step();
      i_cause_clr = 1'b0; i_sw_rst_req = 1'b0;
      chk("clr_vs_set_cause", o_rst_cause, 4'b0010);
      measure(n);
      idle(3);

      // Software request inside the pulse is ignored
      i_sw_rst_req = 1'b1; step(); i_sw_rst_req = 1'b0;
      i_cause_clr = 1'b1; step(); i_cause_clr = 1'b0;
      n = 1;
      while (o_sys_rst && n < 100) begin
         n++;
         i_sw_rst_req = (n == 3);
         step();
      end
      i_sw_rst_req = 1'b0;
      chk("ignore_pulse_len", n, PUL);
      chk("ignore_cause", o_rst_cause, 4'b0000);
      idle(3);

      // Button glitch shorter than the debounce window
      saw = 1'b0;
      i_btn_n = 1'b0;
      for (int i = 0; i < 3; i++) begin step(); saw |= o_sys_rst; end
      i_btn_n = 1'b1;
      for (int i = 0; i < 20; i++) begin step(); saw |= o_sys_rst; end
      chk("glitch_no_rst", saw, 0);

      // Button held long: reset held until debounced release
      saw = 1'b0;
      i_btn_n = 1'b0;
      for (int i = 0; i < 40; i++) begin step(); saw |= o_sys_rst; end
      chk("hold_rst_seen", saw, 1);
      chk("hold_rst_still_high", o_sys_rst, 1);
      chk("hold_cause_btn", o_rst_cause[0], 1);
      i_btn_n = 1'b1;
      idle(20);
      chk("hold_released", o_sys_rst, 0);

      // Watchdog expiry without kicks
      i_wdt_en = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (!o_sys_rst && n < 200);
      i_wdt_en = 1'b0;
      chk("wdt_latency", n, WDT);
      chk("wdt_cause", o_rst_cause[2], 1);
      measure(n);
      chk("wdt_pulse_len", n, PUL);
      idle(3);

      // Regular kicks keep the watchdog quiet
      saw = 1'b0;
      i_wdt_en = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         i_wdt_kick = ((i % 50) == 49);
         step();
         saw |= o_sys_rst;
      end
      i_wdt_kick = 1'b0; i_wdt_en = 1'b0;
      chk("kick_no_rst", saw, 0);

      // Random traffic, checked by the scoreboard every cycle
      btn_left = 5;
      for (int i = 0; i < 3000; i++) begin
         i_rst        = ($urandom_range(0, 599) == 0);
         i_sw_rst_req = ($urandom_range(0, 99) == 0);
         i_cause_clr  = ($urandom_range(0, 79) == 0);
         i_wdt_kick   = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 199) == 0) i_wdt_en = ~i_wdt_en;
         if (btn_left == 0) begin
            i_btn_n  = ~i_btn_n;
            btn_left = $urandom_range(1, 12);
         end else begin
            btn_left--;
         end
         step();
      end
      i_rst = 1'b0; i_sw_rst_req = 1'b0; i_cause_clr = 1'b0; i_wdt_kick = 1'b0;

      repeat (2) @(negedge i_clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
